// File: rtl/cwmac_pkg.sv
// Shared widths and entry/result types for the CWMAC tag verify path.
// The id field is sized for the widest supported ID_W. Users zero-extend into it and slice out of it.
package cwmac_pkg;
  localparam int TAG_W      = 56;
  localparam int ADDR_W     = 26;
  localparam int NONCE_W    = 56;
  localparam int MSG_W      = 512;
  localparam int KEY_ENC_W  = 128;
  localparam int KEY_HASH_W = 512;
  localparam int ID_MAX_W   = 16;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [ADDR_W-1:0]   addr;
    logic [ID_MAX_W-1:0] id;
  } expect_entry_t;

  typedef struct packed {
    logic                ok;
    logic [ADDR_W-1:0]   addr;
    logic [ID_MAX_W-1:0] id;
  } check_result_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/cwmac_tag_fifo.sv
// In-order FIFO of expected-tag entries.
// Full and empty come from a pointer pair that carries one extra wrap bit.
module cwmac_tag_fifo
  import cwmac_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  expect_entry_t wdata,
  input  logic          pop,
  output expect_entry_t rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  expect_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // A push is refused while full, even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/cwmac_tag_checker.sv
// Pairs buffered memory tags with computed MAC tags in order and emits one verify result per line.
// The optional error log is enabled with CWMAC_TAG_CHECK_ERR_LOG_EN.
module cwmac_tag_checker
  import cwmac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_expect_valid,
  output logic                    io_expect_ready,
  input  logic [TAG_W-1:0]        io_expect_bits_tag,
  input  logic [ADDR_W-1:0]       io_expect_bits_addr,
  input  logic [ID_W-1:0]         io_expect_bits_id,
  input  logic                    io_tag_valid,
  output logic                    io_tag_ready,
  input  logic [TAG_W-1:0]        io_tag_bits,
  output logic                    io_result_valid,
  input  logic                    io_result_ready,
  output logic                    io_result_bits_ok,
  output logic [ADDR_W-1:0]       io_result_bits_addr,
  output logic [ID_W-1:0]         io_result_bits_id,
  output logic [$clog2(DEPTH):0]  io_occupancy
`ifdef CWMAC_TAG_CHECK_ERR_LOG_EN
  ,
  output logic [15:0]             io_err_count,
  output logic                    io_err_first_valid,
  output logic [ADDR_W-1:0]       io_err_first_addr,
  output logic [ID_W-1:0]         io_err_first_id
`endif
);
  expect_entry_t             push_ent, head;
  logic                      full, empty, tag_fire, tag_eq;
  logic [$clog2(DEPTH):0]    count;
  check_result_t             res_q;
  logic                      res_vld;
  logic                      unused_id;

  assign push_ent = '{tag: io_expect_bits_tag, addr: io_expect_bits_addr,
                      id: ID_MAX_W'(io_expect_bits_id)};

  // The input is held off while reset is asserted, whatever the FIFO state.
  assign io_expect_ready = reset && !full;
  assign io_tag_ready    = !empty && (!res_vld || io_result_ready);
  assign tag_fire        = io_tag_valid && io_tag_ready;
  assign tag_eq          = (io_tag_bits == head.tag);

  cwmac_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (io_expect_valid && io_expect_ready),
    .wdata (push_ent),
    .pop   (tag_fire),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The result register loads on every tag fire and otherwise holds until it is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_vld <= 1'b0;
      res_q   <= '0;
    end else if (tag_fire) begin
      res_vld <= 1'b1;
      res_q   <= '{ok: tag_eq, addr: head.addr, id: head.id};
    end else if (io_result_ready) begin
      res_vld <= 1'b0;
    end
  end

  assign io_result_valid     = res_vld;
  assign io_result_bits_ok   = res_q.ok;
  assign io_result_bits_addr = res_q.addr;
  assign io_result_bits_id   = res_q.id[ID_W-1:0];
  assign io_occupancy        = count;
  assign unused_id           = ^{head.id, res_q.id};

`ifdef CWMAC_TAG_CHECK_ERR_LOG_EN
  logic err_fire;
  assign err_fire = tag_fire && !tag_eq;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_err_count       <= '0;
      io_err_first_valid <= 1'b0;
      io_err_first_addr  <= '0;
      io_err_first_id    <= '0;
    end else if (err_fire) begin
      io_err_count <= sat_inc16(io_err_count);
      // The first mismatch after reset stays captured.
      if (!io_err_first_valid) begin
        io_err_first_valid <= 1'b1;
        io_err_first_addr  <= head.addr;
        io_err_first_id    <= head.id[ID_W-1:0];
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_res_hold: assert property (@(posedge clock) disable iff (!reset)
    res_vld && !io_result_ready |=> res_vld && $stable(res_q));
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    full |-> !io_expect_ready);
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
    empty |-> !io_tag_ready);
`endif
endmodule

// File: doc/cwmac_tag_checker.md
Name: cwmac_tag_checker

Overview:
- Sits directly downstream of the CWMACOpt tag engine in the memory-protection read path.
- Buffers expected tags fetched from memory (tag/metadata read) in an in-order FIFO.
- Pairs each buffered tag with the next computed tag from the MAC and issues one verify result per line.
- The result goes to the response/integrity-fault logic.

Parameters:
- DEPTH, 4, expected-tag FIFO entries; power of two, 2..16.
- ID_W, 4, request-ID width carried with each line for response matching.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0); deassertion synchronous to clock
- io_expect_valid  in  1  expected-tag entry valid
- io_expect_ready  out  1  FIFO can accept an entry
- io_expect_bits_tag  in  56  tag read from memory
- io_expect_bits_addr  in  26  line address (same encoding as MAC source addr)
- io_expect_bits_id  in  ID_W  request ID
- io_tag_valid  in  1  computed tag from MAC valid
- io_tag_ready  out  1  checker consumes computed tag
- io_tag_bits  in  56  computed tag
- io_result_valid  out  1  verify result valid
- io_result_ready  in  1  downstream accepts result
- io_result_bits_ok  out  1  1 = tags equal
- io_result_bits_addr  out  26  address of checked line
- io_result_bits_id  out  ID_W  ID of checked line
- io_occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

Behaviour:
- Reset (reset==0, async): FIFO pointers=0, io_occupancy=0, io_result_valid=0, result bits=0, io_expect_ready=0 while reset asserted, io_tag_ready=0.
- Handshakes: transfer on valid&&ready. Valid must not depend on ready. Once io_result_valid is raised, it and the result bits stay stable until io_result_ready.
- FIFO push: io_expect_ready = !full. No bypass when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo DEPTH. Full/empty are derived from an extra wrap bit.
- io_tag_ready = !empty && (!io_result_valid || io_result_ready). A computed tag arriving with the FIFO empty stalls; it is never dropped.
- Compare/pop (tag fire):
  - Pop the FIFO head.
  - Register ok = (io_tag_bits == head.tag), full 56-bit equality.
  - Register addr/id from the head and set io_result_valid=1 next cycle.
- Latency: 1 cycle from tag fire to io_result_valid. Full throughput is 1 result/cycle when io_result_ready is held high.
- Result register: if io_result_ready && no new tag fire, io_result_valid clears next cycle.
- Ordering: strictly in-order. The n-th computed tag pairs with the n-th pushed entry.
- Entry pushed in the same cycle the FIFO is empty is not visible to the pop until the next cycle (no flow-through).
- Reset mid-operation: all pending entries and any held result are discarded; no result emitted for them.
- io_occupancy: registered count after the current cycle's push/pop.

Optional Feature:
- Macro: CWMAC_TAG_CHECK_ERR_LOG_EN.
- Defined:
  - Adds outputs io_err_count (16 bits, saturating at 16'hFFFF) and io_err_first_valid / io_err_first_addr (26) / io_err_first_id (ID_W).
  - io_err_count increments on each registered result with ok=0 in the cycle the result is produced.
  - First-error capture is sticky until reset; a later mismatch does not overwrite it.
  - All of these outputs reset to 0.
- Undefined: these ports and their logic are absent; behaviour otherwise identical.

Decomposition:
- Package cwmac_pkg holds:
  - TAG_W=56, ADDR_W=26, NONCE_W=56, MSG_W=512, KEY_ENC_W=128, KEY_HASH_W=512.
  - Typedef expect_entry_t {tag, addr, id}.
  - Typedef check_result_t {ok, addr, id}.
- Sub-module cwmac_tag_fifo: generic sync FIFO of expect_entry_t with DEPTH, push/pop/full/empty/count. The checker instantiates one and adds the compare and result stage.

Test Plan:
- Match: push {tag=56'h9d906ad9445061, addr=26'h11ffe00, id=1}; then tag_valid with 56'h9d906ad9445061 -> next cycle result_valid=1, ok=1, addr=26'h11ffe00, id=1; occupancy 1->0.
- Mismatch: same push; computed tag 56'h9d906ad9445060 -> ok=0. With ERR_LOG_EN: err_count=1, err_first_addr=26'h11ffe00.
- Full/ordering: push DEPTH entries (ids 0..3, distinct tags) with tag_valid low -> expect_ready=0, occupancy=4. Then feed the 4 matching tags -> results ok=1 with ids 0,1,2,3 in order.
- Empty stall: tag_valid=1 with FIFO empty for 5 cycles -> tag_ready=0, no result. Push an entry -> tag fires the following cycle, and the result follows 1 cycle later.
- Backpressure: result_ready=0 for 3 cycles with 2 entries queued and tags valid -> result bits held stable, tag_ready=0. Release -> both results delivered back-to-back.
- Reset mid-op: 2 entries pending and result_valid=1; assert reset for 1 cycle -> result_valid=0 and occupancy=0 immediately (async). After release, a new match yields the correct single result.
